// File: rtl/calc_n_pkg.sv
// Shared opcodes, response codes, capture states and the default-width request layout
// for the calc_n calculator family.
package calc_n_pkg;

  localparam logic [3:0] NO_OP = 4'b0000;
  localparam logic [3:0] ADD   = 4'b0001;
  localparam logic [3:0] SUB   = 4'b0010;
  localparam logic [3:0] MUL   = 4'b0011;
  localparam logic [3:0] SHL   = 4'b0101;
  localparam logic [3:0] SHR   = 4'b0110;

  localparam logic [1:0] NO_RESP = 2'b00;
  localparam logic [1:0] OK      = 2'b01;
  localparam logic [1:0] IN_ERR  = 2'b10;
  localparam logic [1:0] INT_ERR = 2'b11;

  localparam int CALC_DATA_W = 32;

  typedef struct packed {
    logic [3:0]             cmd;
    logic [CALC_DATA_W-1:0] op1;
    logic [CALC_DATA_W-1:0] op2;
  } calc_req_t;

  typedef enum logic {
    CAP_IDLE,
    CAP_OP2
  } cap_state_t;

endpackage

// File: rtl/calc_n_port_queue.sv
// One request port: two-cycle command capture, request FIFO and the sticky
// one-deep overflow flag reported back through the core's output slot.
module calc_n_port_queue
  import calc_n_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] data,
  input  logic              pop,
  input  logic              err_ack,
  output logic              empty,
  output logic              full,
  output logic              err_pending,
  output logic [3:0]        head_cmd,
  output logic [DATA_W-1:0] head_op1,
  output logic [DATA_W-1:0] head_op2
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(QUEUE_DEPTH);

  typedef struct packed {
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } req_t;

  cap_state_t        state, state_nxt;
  logic              push_req, accept, drop;
  logic [3:0]        cmd_lat;
  logic [DATA_W-1:0] op1_lat;
  req_t              mem [QUEUE_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CAP_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    case (state)
      CAP_IDLE: if (cmd != NO_OP) state_nxt = CAP_OP2;
      CAP_OP2: begin
        push_req  = 1'b1;
        state_nxt = CAP_IDLE;
      end
      default: state_nxt = CAP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == CAP_IDLE && cmd != NO_OP) begin
      cmd_lat <= cmd;
      op1_lat <= data;
    end
  end

  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign accept = push_req && (!full || pop);
  assign drop   = push_req && !accept;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= '{cmd: cmd_lat, op1: op1_lat, op2: data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err_pending <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      err_pending <= (err_pending && !err_ack) || drop;
    end
  end

  assign head_cmd = mem[rd_ptr].cmd;
  assign head_op1 = mem[rd_ptr].op1;
  assign head_op2 = mem[rd_ptr].op2;

endmodule

// File: rtl/calc_n_core.sv
// Multi-port calculator core: per-port request queues, round-robin arbiter and a shared
// 2-stage ALU with routed responses. Define CALC_MUL_EN to enable opcode 0011 (multiply).
module calc_n_core
  import calc_n_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_W      = 32,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
  input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
  output logic [2*NUM_PORTS-1:0]      out_resp,
  output logic [DATA_W*NUM_PORTS-1:0] out_data,
  output logic [NUM_PORTS-1:0]        queue_full
);

  localparam int PW  = $clog2(NUM_PORTS);
  localparam int SHW = $clog2(DATA_W);
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);
  localparam logic [PW-1:0] PORT_ONE  = PW'(1);

  function automatic logic [DATA_W+1:0] alu(input logic [3:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   sum;
    logic [SHW-1:0]    sh;
`ifdef CALC_MUL_EN
    logic [2*DATA_W-1:0] prod;
    prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif
    sum = {1'b0, a} + {1'b0, b};
    sh  = b[SHW-1:0];
    alu = {IN_ERR, {DATA_W{1'b0}}};
    case (op)
      ADD: if (!sum[DATA_W]) alu = {OK, sum[DATA_W-1:0]};
      SUB: if (b <= a)       alu = {OK, a - b};
`ifdef CALC_MUL_EN
      MUL: if (prod[2*DATA_W-1:DATA_W] == '0) alu = {OK, prod[DATA_W-1:0]};
`endif
      SHL: alu = {OK, a << sh};
      SHR: alu = {OK, a >> sh};
      default: ;
    endcase
  endfunction

  logic [NUM_PORTS-1:0] empty, pop, err_pending, err_ack, alu_slot;
  logic [3:0]           head_cmd [NUM_PORTS];
  logic [DATA_W-1:0]    head_op1 [NUM_PORTS];
  logic [DATA_W-1:0]    head_op2 [NUM_PORTS];

  logic [PW-1:0]        rr_ptr, grant_idx, cand;
  logic                 grant_vld;

  logic                 vld_p1, vld_p2;
  logic [3:0]           cmd_p1;
  logic [DATA_W-1:0]    op1_p1, op2_p1, data_p2;
  logic [PW-1:0]        port_p1, port_p2;
  logic [1:0]           resp_p2;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc_n_port_queue #(
      .DATA_W      (DATA_W),
      .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
      .clk         (c_clk),
      .rst_n       (reset),
      .cmd         (req_cmd_in[4*p +: 4]),
      .data        (req_data_in[DATA_W*p +: DATA_W]),
      .pop         (pop[p]),
      .err_ack     (err_ack[p]),
      .empty       (empty[p]),
      .full        (queue_full[p]),
      .err_pending (err_pending[p]),
      .head_cmd    (head_cmd[p]),
      .head_op1    (head_op1[p]),
      .head_op2    (head_op2[p])
    );
    assign alu_slot[p] = vld_p2 && (port_p2 == PW'(p));
    assign err_ack[p]  = err_pending[p] && !alu_slot[p];
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    pop       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!grant_vld && !empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_vld) pop[grant_idx] = 1'b1;
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (grant_vld) rr_ptr <= (grant_idx == LAST_PORT) ? '0 : grant_idx + PORT_ONE;
      vld_p1 <= grant_vld;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 1: operands and originating port of the granted request
  always_ff @(posedge c_clk) begin
    if (grant_vld) begin
      cmd_p1  <= head_cmd[grant_idx];
      op1_p1  <= head_op1[grant_idx];
      op2_p1  <= head_op2[grant_idx];
      port_p1 <= grant_idx;
    end
  end

  // Stage 2: ALU result
  always_ff @(posedge c_clk) begin
    if (vld_p1) begin
      {resp_p2, data_p2} <= alu(cmd_p1, op1_p1, op2_p1);
      port_p2            <= port_p1;
    end
  end

  // Output stage: an ALU response owns the slot; a pending overflow waits for a free cycle
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      out_resp <= '0;
      out_data <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (alu_slot[p]) begin
          out_resp[2*p +: 2]           <= resp_p2;
          out_data[DATA_W*p +: DATA_W] <= data_p2;
        end else if (err_pending[p]) begin
          out_resp[2*p +: 2]           <= INT_ERR;
          out_data[DATA_W*p +: DATA_W] <= '0;
        end else begin
          out_resp[2*p +: 2]           <= NO_RESP;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_n_core.sv
// Bench for calc_n_core: directed literal cases plus randomized multi-port traffic,
// compared every cycle against a queue-level reference model.
`timescale 1ns/1ps
module tb_calc_n_core;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int QD = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [4*NP-1:0] req_cmd = '0;
  logic [DW*NP-1:0] req_data = '0;
  logic [2*NP-1:0] out_resp;
  logic [DW*NP-1:0] out_data;
  logic [NP-1:0]   queue_full;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  calc_n_core #(.NUM_PORTS(NP), .DATA_W(DW), .QUEUE_DEPTH(QD)) dut (
    .c_clk       (clk),
    .reset       (rst_n),
    .req_cmd_in  (req_cmd),
    .req_data_in (req_data),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .queue_full  (queue_full)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]    cmd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } mreq_t;

  mreq_t         mq [NP][$];
  int            rr, mi;
  bit            cap_busy [NP];
  logic [3:0]    cap_cmd  [NP];
  logic [DW-1:0] cap_a    [NP];
  bit            err_flag [NP];
  bit            ack      [NP];
  bit            s1_v, s2_v, mdrop;
  int            s1_port, s2_port;
  mreq_t         s1;
  logic [1:0]    s2_resp;
  logic [DW-1:0] s2_data, md;
  logic [3:0]    mc;
  logic [1:0]    exp_resp [NP];
  logic [DW-1:0] exp_data [NP];
  bit            exp_full [NP];

  function automatic logic [DW+1:0] ref_alu(input logic [3:0] c, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [63:0] x;
    case (c)
      4'd1: begin
        x = 64'(a) + 64'(b);
        return (x > 64'hFFFF_FFFF) ? {2'b10, 32'd0} : {2'b01, x[31:0]};
      end
      4'd2: return (b > a) ? {2'b10, 32'd0} : {2'b01, a - b};
`ifdef CALC_MUL_EN
      4'd3: begin
        x = 64'(a) * 64'(b);
        return (x > 64'hFFFF_FFFF) ? {2'b10, 32'd0} : {2'b01, x[31:0]};
      end
`endif
      4'd5: return {2'b01, a << (b % 32)};
      4'd6: return {2'b01, a >> (b % 32)};
      default: return {2'b10, 32'd0};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        mq[p].delete();
        cap_busy[p] = 1'b0;
        err_flag[p] = 1'b0;
        exp_resp[p] = 2'b00;
        exp_data[p] = '0;
        exp_full[p] = 1'b0;
      end
      rr   = 0;
      s1_v = 1'b0;
      s2_v = 1'b0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        ack[p] = 1'b0;
        if (s2_v && s2_port == p) begin
          exp_resp[p] = s2_resp;
          exp_data[p] = s2_data;
        end else if (err_flag[p]) begin
          exp_resp[p] = 2'b11;
          exp_data[p] = '0;
          ack[p]      = 1'b1;
        end else begin
          exp_resp[p] = 2'b00;
        end
      end
      s2_v = s1_v;
      if (s1_v) begin
        {s2_resp, s2_data} = ref_alu(s1.cmd, s1.a, s1.b);
        s2_port = s1_port;
      end
      s1_v = 1'b0;
      for (int i = 0; i < NP; i++) begin
        mi = (rr + i) % NP;
        if (!s1_v && mq[mi].size() > 0) begin
          s1      = mq[mi].pop_front();
          s1_v    = 1'b1;
          s1_port = mi;
        end
      end
      if (s1_v) rr = (s1_port + 1) % NP;
      for (int p = 0; p < NP; p++) begin
        mc    = req_cmd[4*p +: 4];
        md    = req_data[DW*p +: DW];
        mdrop = 1'b0;
        if (cap_busy[p]) begin
          cap_busy[p] = 1'b0;
          if (mq[p].size() < QD) mq[p].push_back('{cap_cmd[p], cap_a[p], md});
          else mdrop = 1'b1;
        end else if (mc != 4'd0) begin
          cap_busy[p] = 1'b1;
          cap_cmd[p]  = mc;
          cap_a[p]    = md;
        end
        err_flag[p] = (err_flag[p] && !ack[p]) || mdrop;
        exp_full[p] = (mq[p].size() == QD);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NP; p++) begin
        check($sformatf("model_resp_p%0d", p), 64'(out_resp[2*p +: 2]), 64'(exp_resp[p]));
        check($sformatf("model_data_p%0d", p), 64'(out_data[DW*p +: DW]), 64'(exp_data[p]));
        check($sformatf("model_full_p%0d", p), 64'(queue_full[p]), 64'(exp_full[p]));
      end
    end
  end

  // ---------------- stimulus ----------------
  bit phase [NP];

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic run_op(input int p, input logic [3:0] c, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [1:0] er,
                        input logic [DW-1:0] ed, input string nm);
    req_cmd[4*p +: 4]   = c;
    req_data[DW*p +: DW] = a;
    @(posedge clk); #2;
    req_cmd[4*p +: 4]   = 4'd0;
    req_data[DW*p +: DW] = b;
    @(posedge clk); #2;
    req_data[DW*p +: DW] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check($sformatf("%s_resp_p%0d", nm, p), 64'(out_resp[2*p +: 2]), 64'(er));
    check($sformatf("%s_data_p%0d", nm, p), 64'(out_data[DW*p +: DW]), 64'(ed));
    for (int q = 0; q < NP; q++)
      if (q != p) check($sformatf("%s_idle_p%0d", nm, q), 64'(out_resp[2*q +: 2]), 64'd0);
    @(posedge clk); #2;
  endtask

  function automatic logic [DW-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] ops [5] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6};
    if ($urandom_range(0, 2) != 0) return ops[$urandom_range(0, 4)];
    return 4'($urandom_range(1, 15));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int total, errs, seen;
    bit full_seen;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("reset_resp", 64'(out_resp), 64'd0);
    check("reset_data", 64'(out_data[63:0]), 64'd0);
    check("reset_full", 64'(queue_full), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int p = 0; p < NP; p++)
      run_op(p, 4'd1, 32'h8000_2345, 32'h0001_0000, 2'b01, 32'h8001_2345, "add");
    run_op(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 32'd0, "add_carry");
    run_op(1, 4'd2, 32'd5, 32'd6, 2'b10, 32'd0, "sub_neg");
    run_op(2, 4'd2, 32'd6, 32'd5, 2'b01, 32'd1, "sub_pos");
    run_op(3, 4'd5, 32'h0000_0001, 32'h0000_0021, 2'b01, 32'h0000_0002, "shl");
    run_op(0, 4'd6, 32'h8000_0000, 32'd31, 2'b01, 32'h0000_0001, "shr");
    run_op(1, 4'd7, 32'd3, 32'd4, 2'b10, 32'd0, "bad_op");
`ifdef CALC_MUL_EN
    run_op(2, 4'd3, 32'd1234, 32'd1000, 2'b01, 32'd1234000, "mul");
    run_op(3, 4'd3, 32'h0001_0000, 32'h0001_0000, 2'b10, 32'd0, "mul_ovf");
`else
    run_op(2, 4'd3, 32'd1234, 32'd1000, 2'b10, 32'd0, "mul_off");
`endif

    // all ports at once after reset: served 0,1,2,3 on consecutive cycles
    do_reset();
    for (int p = 0; p < NP; p++) begin
      req_cmd[4*p +: 4]    = 4'd1;
      req_data[DW*p +: DW] = 32'd1;
    end
    @(posedge clk); #2;
    req_cmd = '0;
    @(posedge clk); #2;
    req_data = '0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < NP; k++) begin
      @(negedge clk);
      for (int q = 0; q < NP; q++)
        check($sformatf("rr_resp_c%0d_p%0d", k, q), 64'(out_resp[2*q +: 2]),
              (q == k) ? 64'd1 : 64'd0);
      check($sformatf("rr_data_p%0d", k), 64'(out_data[DW*k +: DW]), 64'd2);
    end
    @(posedge clk); #2;

    // back-to-back adds on every port overflow the queues
    total = 0; errs = 0; full_seen = 1'b0;
    for (int cyc = 0; cyc < 52; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        if (cyc < 12) begin
          req_cmd[4*p +: 4]    = (cyc % 2 == 0) ? 4'd1 : 4'd0;
          req_data[DW*p +: DW] = 32'($urandom_range(0, 1000));
        end else begin
          req_cmd[4*p +: 4]    = 4'd0;
          req_data[DW*p +: DW] = '0;
        end
      end
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (out_resp[2*p +: 2] != 2'b00) total++;
        if (out_resp[2*p +: 2] == 2'b11) errs++;
      end
      if (queue_full != '0) full_seen = 1'b1;
      @(posedge clk); #2;
    end
    check("burst_total_resp", 64'(total), 64'd24);
    check("burst_full_seen", 64'(full_seen), 64'd1);
    check("burst_drop_seen", 64'(errs > 0), 64'd1);

    // reset one cycle after op2 discards everything in flight
    for (int p = 0; p < NP; p++) begin
      req_cmd[4*p +: 4]    = 4'd1;
      req_data[DW*p +: DW] = 32'd5;
    end
    @(posedge clk); #2;
    req_cmd = '0;
    @(posedge clk); #2;
    req_data = '0;
    do_reset();
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_resp != '0) seen++;
    end
    check("reset_midop_no_resp", 64'(seen), 64'd0);
    @(posedge clk); #2;

    // randomized traffic, light then heavy load
    for (int p = 0; p < NP; p++) phase[p] = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        if (phase[p]) begin
          req_cmd[4*p +: 4]    = 4'($urandom_range(0, 15));
          req_data[DW*p +: DW] = rand_operand();
          phase[p] = 1'b0;
        end else if ($urandom_range(0, 3) < ((cyc < 600) ? 1 : 3)) begin
          req_cmd[4*p +: 4]    = rand_op();
          req_data[DW*p +: DW] = rand_operand();
          phase[p] = 1'b1;
        end else begin
          req_cmd[4*p +: 4]    = 4'd0;
          req_data[DW*p +: DW] = 32'($urandom);
        end
      end
      @(posedge clk); #2;
    end
    req_cmd  = '0;
    req_data = '0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
